// File: rtl/loot_spawner_if.sv
// Player/raster inputs and collect/render outputs of the loot spawner, grouped as one bus.
// The testbench or game top drives the master side; loot_spawner sits on the slave side.
interface loot_spawner_if #(
    parameter int NUM_SLOTS = 4
);
    logic                 SpawnEnable;
    logic [9:0]           P1X, P1Y, P2X, P2Y;
    logic                 P1Block, P2Block;
    logic [9:0]           DrawX, DrawY;
    logic [1:0]           P1Collect, P2Collect;
    logic                 LootPixel;
    logic [1:0]           LootValue;
    logic [3:0]           LootPixelX, LootPixelY;
    logic [NUM_SLOTS-1:0] SlotActive;

    modport master (
        output SpawnEnable, P1X, P1Y, P2X, P2Y, P1Block, P2Block, DrawX, DrawY,
        input  P1Collect, P2Collect, LootPixel, LootValue, LootPixelX, LootPixelY, SlotActive
    );

    modport slave (
        input  SpawnEnable, P1X, P1Y, P2X, P2Y, P1Block, P2Block, DrawX, DrawY,
        output P1Collect, P2Collect, LootPixel, LootValue, LootPixelX, LootPixelY, SlotActive
    );
endinterface

// File: rtl/loot_spawner.sv
// Frame-rate loot item manager: LFSR spawning, player pickup pulses and per-pixel render hit.
// Define LOOT_DECAY_EN to give each item a LIFETIME_FRAMES life counter.
module loot_spawner #(
    parameter int          NUM_SLOTS      = 4,
    parameter int          RESPAWN_FRAMES = 120,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
`ifdef LOOT_DECAY_EN
    ,
    parameter int          LIFETIME_FRAMES = 600
`endif
) (
    input logic           FrameClk,
    input logic           ResetN,
    loot_spawner_if.slave bus
);

    localparam int              TW        = $clog2(RESPAWN_FRAMES + 1);
    localparam logic [TW-1:0]   RESPAWN_T = TW'(RESPAWN_FRAMES);
    localparam logic [10:0]     ITEM_SZ   = 11'd16;
    localparam logic [10:0]     PLAYER_SZ = 11'd32;

    // Strict AABB test; boxes that only share an edge do not overlap.
    function automatic logic overlap(
        input logic [10:0] ax, input logic [10:0] ay, input logic [10:0] asz,
        input logic [10:0] bx, input logic [10:0] by, input logic [10:0] bsz);
        return (ax < bx + bsz) && (bx < ax + asz) && (ay < by + bsz) && (by < ay + asz);
    endfunction

    logic [15:0]                   lfsr_q, lfsr_d;
    logic [NUM_SLOTS-1:0]          active_q, active_d;
    logic [NUM_SLOTS-1:0][TW-1:0]  timer_q, timer_d;
    logic [NUM_SLOTS-1:0][9:0]     x_q, x_d, y_q, y_d;
    logic [NUM_SLOTS-1:0][1:0]     val_q, val_d;
    logic [1:0]                    p1c_q, p1c_d, p2c_q, p2c_d;

`ifdef LOOT_DECAY_EN
    localparam int            LW     = $clog2(LIFETIME_FRAMES + 1);
    localparam logic [LW-1:0] LIFE_T = LW'(LIFETIME_FRAMES);
    logic [NUM_SLOTS-1:0][LW-1:0] life_q, life_d;
`endif

    logic [4:0]           col;
    logic [10:0]          cand_x, cand_y;
    logic [1:0]           cand_val;
    logic                 cand_blocked;
    logic [NUM_SLOTS-1:0] p1_ovl, p2_ovl;

    assign lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    // Columns 19..31 fold back by 16 so every candidate stays on the 19-column grid.
    assign col      = (lfsr_q[4:0] > 5'd18) ? (lfsr_q[4:0] - 5'd16) : lfsr_q[4:0];
    assign cand_x   = 11'd100 + {1'b0, col, 5'b0};
    assign cand_y   = 11'd129 + {3'b0, lfsr_q[7:5], 5'b0};
    assign cand_val = (lfsr_q[9:8] == 2'd0) ? 2'd1 : lfsr_q[9:8];

    always_comb begin : overlap_c
        cand_blocked = overlap(cand_x, cand_y, ITEM_SZ, {1'b0, bus.P1X}, {1'b0, bus.P1Y}, PLAYER_SZ)
                    || overlap(cand_x, cand_y, ITEM_SZ, {1'b0, bus.P2X}, {1'b0, bus.P2Y}, PLAYER_SZ);
        p1_ovl = '0;
        p2_ovl = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            p1_ovl[i] = active_q[i] && !bus.P1Block &&
                        overlap({1'b0, x_q[i]}, {1'b0, y_q[i]}, ITEM_SZ, {1'b0, bus.P1X}, {1'b0, bus.P1Y}, PLAYER_SZ);
            p2_ovl[i] = active_q[i] && !bus.P2Block &&
                        overlap({1'b0, x_q[i]}, {1'b0, y_q[i]}, ITEM_SZ, {1'b0, bus.P2X}, {1'b0, bus.P2Y}, PLAYER_SZ);
            if (active_q[i] && overlap(cand_x, cand_y, ITEM_SZ, {1'b0, x_q[i]}, {1'b0, y_q[i]}, ITEM_SZ))
                cand_blocked = 1'b1;
        end
    end

    always_comb begin : next_c
        logic p1_done, p2_done, spawn_done;
        p1_done    = 1'b0;
        p2_done    = 1'b0;
        spawn_done = 1'b0;
        active_d   = active_q;
        timer_d    = timer_q;
        x_d        = x_q;
        y_d        = y_q;
        val_d      = val_q;
        p1c_d      = '0;
        p2c_d      = '0;
`ifdef LOOT_DECAY_EN
        life_d     = life_q;
`endif
        for (int i = 0; i < NUM_SLOTS; i++)
            if (!active_q[i] && timer_q[i] != '0) timer_d[i] = timer_q[i] - TW'(1);

        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!p1_done && p1_ovl[i]) begin
                p1_done     = 1'b1;
                p1c_d       = val_q[i];
                active_d[i] = 1'b0;
                timer_d[i]  = RESPAWN_T;
            end
        end
        // active_d already reflects player one's pickup, so player two skips that slot.
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!p2_done && p2_ovl[i] && active_d[i]) begin
                p2_done     = 1'b1;
                p2c_d       = val_q[i];
                active_d[i] = 1'b0;
                timer_d[i]  = RESPAWN_T;
            end
        end

`ifdef LOOT_DECAY_EN
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (active_d[i]) begin
                if (life_q[i] <= LW'(1)) begin
                    active_d[i] = 1'b0;
                    timer_d[i]  = RESPAWN_T;
                end else begin
                    life_d[i] = life_q[i] - LW'(1);
                end
            end
        end
`endif

        if (!cand_blocked) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (!spawn_done && !active_q[i] && timer_q[i] == '0) begin
                    spawn_done  = 1'b1;
                    active_d[i] = 1'b1;
                    x_d[i]      = cand_x[9:0];
                    y_d[i]      = cand_y[9:0];
                    val_d[i]    = cand_val;
`ifdef LOOT_DECAY_EN
                    life_d[i]   = LIFE_T;
`endif
                end
            end
        end

        if (!bus.SpawnEnable) begin
            active_d = '0;
            timer_d  = '0;
            p1c_d    = '0;
            p2c_d    = '0;
        end
    end

    always_ff @(posedge FrameClk) begin
        if (!ResetN) begin
            lfsr_q   <= LFSR_SEED;
            active_q <= '0;
            timer_q  <= '0;
            x_q      <= '0;
            y_q      <= '0;
            val_q    <= '0;
            p1c_q    <= '0;
            p2c_q    <= '0;
        end else begin
            lfsr_q   <= lfsr_d;
            active_q <= active_d;
            timer_q  <= timer_d;
            x_q      <= x_d;
            y_q      <= y_d;
            val_q    <= val_d;
            p1c_q    <= p1c_d;
            p2c_q    <= p2c_d;
        end
    end

`ifdef LOOT_DECAY_EN
    always_ff @(posedge FrameClk) begin
        if (!ResetN) life_q <= '0;
        else         life_q <= life_d;
    end
`endif

    logic       pix;
    logic [1:0] pix_val;
    logic [3:0] pix_ox, pix_oy;

    always_comb begin : render_c
        pix     = 1'b0;
        pix_val = '0;
        pix_ox  = '0;
        pix_oy  = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!pix && active_q[i] &&
                {1'b0, bus.DrawX} >= {1'b0, x_q[i]} && {1'b0, bus.DrawX} < {1'b0, x_q[i]} + ITEM_SZ &&
                {1'b0, bus.DrawY} >= {1'b0, y_q[i]} && {1'b0, bus.DrawY} < {1'b0, y_q[i]} + ITEM_SZ) begin
                pix     = 1'b1;
                pix_val = val_q[i];
                pix_ox  = bus.DrawX[3:0] - x_q[i][3:0];
                pix_oy  = bus.DrawY[3:0] - y_q[i][3:0];
            end
        end
    end

    assign bus.P1Collect  = p1c_q;
    assign bus.P2Collect  = p2c_q;
    assign bus.LootPixel  = pix;
    assign bus.LootValue  = pix_val;
    assign bus.LootPixelX = pix_ox;
    assign bus.LootPixelY = pix_oy;
    assign bus.SlotActive = active_q;

endmodule

// File: tb/tb_loot_spawner.sv
// Directed bench for loot_spawner: fill order, render table, pickup corners, clear/reset and persistence.
// Positions after reset come from hand-stepping LFSR 16'hACE1; only the respawn check uses a small model.
module tb_loot_spawner;
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    loot_spawner_if #(.NUM_SLOTS(4)) bus_if ();

    loot_spawner #(
        .NUM_SLOTS(4), .RESPAWN_FRAMES(120), .LFSR_SEED(16'hACE1)
`ifdef LOOT_DECAY_EN
        , .LIFETIME_FRAMES(10)
`endif
    ) dut (
        .FrameClk(clk),
        .ResetN  (rstn),
        .bus     (bus_if)
    );

    int nvec = 0;
    int nerr = 0;

    function automatic logic [15:0] lstep(input logic [15:0] l);
        return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    logic [15:0] m_lfsr;
    always @(posedge clk) m_lfsr <= !rstn ? 16'hACE1 : lstep(m_lfsr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic park();
        bus_if.P1X = 10'd292; bus_if.P1Y = 10'd400;
        bus_if.P2X = 10'd516; bus_if.P2Y = 10'd400;
        bus_if.P1Block = 1'b0; bus_if.P2Block = 1'b0;
    endtask

    // Slots after fill: 0=(132,353,v1) 1=(612,225,v2) 2=(356,161,v1) 3=(484,257,v1)
    task automatic reset_and_fill();
        logic [3:0] fill_exp [4];
        fill_exp = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
        rstn = 1'b0;
        bus_if.SpawnEnable = 1'b1;
        park();
        tick(); tick();
        chk("reset SlotActive", bus_if.SlotActive, 4'b0000);
        chk("reset P1Collect",  bus_if.P1Collect, 2'd0);
        chk("reset P2Collect",  bus_if.P2Collect, 2'd0);
        rstn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("fill frame %0d", k), bus_if.SlotActive, fill_exp[k]);
        end
    endtask

    typedef struct {
        logic [9:0]  dx;
        logic [9:0]  dy;
        logic [10:0] exp;   // {LootPixel, LootValue, LootPixelX, LootPixelY}
    } rvec_t;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rvec_t rtab [11];
        int    col, cx, cy, cv;
        bit    clear, early;
        int    sx [3];
        int    sy [3];

        rtab[0]  = '{10'd132, 10'd353, {1'b1, 2'd1, 4'd0,  4'd0}};
        rtab[1]  = '{10'd140, 10'd360, {1'b1, 2'd1, 4'd8,  4'd7}};
        rtab[2]  = '{10'd147, 10'd368, {1'b1, 2'd1, 4'd15, 4'd15}};
        rtab[3]  = '{10'd148, 10'd353, 11'd0};
        rtab[4]  = '{10'd131, 10'd360, 11'd0};
        rtab[5]  = '{10'd140, 10'd369, 11'd0};
        rtab[6]  = '{10'd620, 10'd230, {1'b1, 2'd2, 4'd8,  4'd5}};
        rtab[7]  = '{10'd627, 10'd240, {1'b1, 2'd2, 4'd15, 4'd15}};
        rtab[8]  = '{10'd356, 10'd161, {1'b1, 2'd1, 4'd0,  4'd0}};
        rtab[9]  = '{10'd499, 10'd272, {1'b1, 2'd1, 4'd15, 4'd15}};
        rtab[10] = '{10'd0,   10'd0,   11'd0};
        sx = '{612, 356, 484};
        sy = '{225, 161, 257};

        bus_if.DrawX = '0;
        bus_if.DrawY = '0;

        // Fill, render table, pickup of slot0 and its respawn
        reset_and_fill();
        for (int i = 0; i < 11; i++) begin
            bus_if.DrawX = rtab[i].dx;
            bus_if.DrawY = rtab[i].dy;
            #1;
            chk($sformatf("render vec %0d", i),
                {bus_if.LootPixel, bus_if.LootValue, bus_if.LootPixelX, bus_if.LootPixelY}, rtab[i].exp);
        end

        bus_if.P1X = 10'd124; bus_if.P1Y = 10'd345;
        tick();
        chk("slot0 pickup P1Collect", bus_if.P1Collect, 2'd1);
        chk("slot0 pickup P2Collect", bus_if.P2Collect, 2'd0);
        chk("slot0 removed", bus_if.SlotActive, 4'b1110);
        park();
        early = 1'b0;
        tick();
        chk("pulse lasts one frame", bus_if.P1Collect, 2'd0);
        if (bus_if.SlotActive[0]) early = 1'b1;
        for (int k = 2; k <= 120; k++) begin
            tick();
            if (bus_if.SlotActive[0]) early = 1'b1;
        end
        chk("no respawn within 120 frames", early, 1'b0);
        col = int'(m_lfsr[4:0]);
        if (col > 18) col -= 16;
        cx = 100 + 32 * col;
        cy = 129 + 32 * int'(m_lfsr[7:5]);
        cv = (m_lfsr[9:8] == 2'd0) ? 1 : int'(m_lfsr[9:8]);
        clear = 1'b1;
        for (int s = 0; s < 3; s++)
            if (cx < sx[s] + 16 && sx[s] < cx + 16 && cy < sy[s] + 16 && sy[s] < cy + 16) clear = 1'b0;
        tick();
        if (clear) begin
            chk("respawn on frame 121", bus_if.SlotActive, 4'b1111);
            bus_if.DrawX = 10'(cx);
            bus_if.DrawY = 10'(cy);
            #1;
            chk("respawned item render", {bus_if.LootPixel, bus_if.LootValue}, {1'b1, 2'(cv)});
        end else begin
            chk("blocked respawn skipped", bus_if.SlotActive, 4'b1110);
        end

        // Touching edge, shared slot, blocked player one
        reset_and_fill();
        bus_if.P1X = 10'd452; bus_if.P1Y = 10'd249;
        tick();
        chk("touching edge no collect", bus_if.P1Collect, 2'd0);
        chk("touching edge slot kept", bus_if.SlotActive, 4'b1111);
        bus_if.P1X = 10'd453;
        tick();
        chk("one pixel in collects", bus_if.P1Collect, 2'd1);
        chk("slot3 removed", bus_if.SlotActive, 4'b0111);
        park();
        bus_if.P1X = 10'd604; bus_if.P1Y = 10'd217;
        bus_if.P2X = 10'd604; bus_if.P2Y = 10'd217;
        tick();
        chk("shared slot P1Collect", bus_if.P1Collect, 2'd2);
        chk("shared slot P2Collect", bus_if.P2Collect, 2'd0);
        chk("slot1 removed", bus_if.SlotActive, 4'b0101);
        bus_if.P1X = 10'd348; bus_if.P1Y = 10'd153;
        bus_if.P2X = 10'd348; bus_if.P2Y = 10'd153;
        bus_if.P1Block = 1'b1;
        tick();
        chk("blocked P1Collect", bus_if.P1Collect, 2'd0);
        chk("blocked P2Collect", bus_if.P2Collect, 2'd1);
        chk("slot2 removed by P2", bus_if.SlotActive, 4'b0001);

        // Two players, two different slots in the same frame
        reset_and_fill();
        bus_if.P1X = 10'd124; bus_if.P1Y = 10'd345;
        bus_if.P2X = 10'd348; bus_if.P2Y = 10'd153;
        tick();
        chk("dual P1Collect", bus_if.P1Collect, 2'd1);
        chk("dual P2Collect", bus_if.P2Collect, 2'd1);
        chk("dual slots removed", bus_if.SlotActive, 4'b1010);

        // SpawnEnable drop wins over a pickup
        reset_and_fill();
        bus_if.P1X = 10'd604; bus_if.P1Y = 10'd217;
        bus_if.SpawnEnable = 1'b0;
        tick();
        chk("disable clears field", bus_if.SlotActive, 4'b0000);
        chk("disable no collect", bus_if.P1Collect, 2'd0);

        // Reset during a pickup frame
        reset_and_fill();
        bus_if.P1X = 10'd124; bus_if.P1Y = 10'd345;
        rstn = 1'b0;
        tick();
        chk("reset beats collect", bus_if.P1Collect, 2'd0);
        chk("reset clears slots", bus_if.SlotActive, 4'b0000);

        // Item lifetime
        reset_and_fill();
`ifdef LOOT_DECAY_EN
        for (int k = 0; k < 6; k++) tick();
        chk("item alive at frame 9", bus_if.SlotActive[0], 1'b1);
        tick();
        chk("item expired at frame 10", bus_if.SlotActive[0], 1'b0);
        chk("expiry gives no pulse", bus_if.P1Collect, 2'd0);
`else
        early = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            tick();
            if (bus_if.SlotActive != 4'b1111) early = 1'b1;
        end
        chk("items persist 1000 frames", early, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
